// File: rtl/rr_grant_sched.sv
// Four-way round-robin grant scheduler with a one-cycle turnaround gap between owners.
// Optional forced release after MAX_HOLD contended cycles: define RR_GRANT_SCHED_HOLD_LIMIT_EN.
module rr_grant_sched #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned ID_W     = 2,
    parameter int unsigned HOLD_W   = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

    if (NREQ != (2 ** ID_W)) begin : g_bad_nreq
        $error("NREQ must equal 2**ID_W");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_max_hold
        $error("MAX_HOLD out of range for HOLD_W");
    end

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;
`endif

    logic            win_vld;
    logic [ID_W-1:0] win_id;
    logic [ID_W-1:0] scan_idx;

    // Scan from ptr upward; the ID_W-bit add wraps NREQ-1 -> 0.
    always_comb begin
        win_vld  = 1'b0;
        win_id   = ptr_q;
        scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = ptr_q + ID_W'(i);
            if (!win_vld && req[scan_idx]) begin
                win_vld = 1'b1;
                win_id  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_id_d   = gnt_id_q;
        ptr_d      = ptr_q;
`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            StIdle, StGap: begin
                if (win_vld) begin
                    state_d    = StGrant;
                    gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                    gnt_id_d   = win_id;
                    ptr_d      = win_id + ID_W'(1);
`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
                    hold_cnt_d = HOLD_W'(1);
`endif
                end else begin
                    state_d = StIdle;
                    gnt_d   = '0;
                end
            end
            StGrant: begin
                if (!req[gnt_id_q]) begin
                    state_d = StGap;
                    gnt_d   = '0;
`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
                end else if (hold_cnt_q == HOLD_W'(MAX_HOLD) && |(req & ~gnt_q)) begin
                    state_d   = StGap;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= '0;
`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_id_q   <= gnt_id_d;
            ptr_q      <= ptr_d;
`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q != StIdle);
`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_sched.sv
// Directed bench for rr_grant_sched: vector table for round-robin order plus
// hand-written hold-limit, lone-owner and mid-grant reset sequences.
module tb_rr_grant_sched;

`ifdef RR_GRANT_SCHED_HOLD_LIMIT_EN
    localparam bit HoldEn = 1'b1;
`else
    localparam bit HoldEn = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vecs[23];

    rr_grant_sched #(
        .NREQ    (4),
        .ID_W    (2),
        .HOLD_W  (4),
        .MAX_HOLD(8)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                             input logic eb, input logic et);
        n_chk++;
        if (gnt !== eg) begin
            n_fail++;
            $display("FAIL %s gnt: got %b expected %b", tag, gnt, eg);
        end
        n_chk++;
        if (gnt_id !== ei) begin
            n_fail++;
            $display("FAIL %s gnt_id: got %0d expected %0d", tag, gnt_id, ei);
        end
        n_chk++;
        if (busy !== eb) begin
            n_fail++;
            $display("FAIL %s busy: got %b expected %b", tag, busy, eb);
        end
        n_chk++;
        if (timeout !== et) begin
            n_fail++;
            $display("FAIL %s timeout: got %b expected %b", tag, timeout, et);
        end
    endtask

    // Drive req for the next rising edge, then sample 1 time unit after it.
    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Round robin 0,1,2,3 at 3 cycles each with a gap, then "previous owner scanned last".
        vecs[0]  = '{4'b0000, 4'b0000, 2'd0, 1'b0};
        vecs[1]  = '{4'b0001, 4'b0001, 2'd0, 1'b1};
        vecs[2]  = '{4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[3]  = '{4'b1111, 4'b0001, 2'd0, 1'b1};
        vecs[4]  = '{4'b1110, 4'b0000, 2'd0, 1'b1};
        vecs[5]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
        vecs[6]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
        vecs[7]  = '{4'b1110, 4'b0010, 2'd1, 1'b1};
        vecs[8]  = '{4'b1100, 4'b0000, 2'd1, 1'b1};
        vecs[9]  = '{4'b1100, 4'b0100, 2'd2, 1'b1};
        vecs[10] = '{4'b1100, 4'b0100, 2'd2, 1'b1};
        vecs[11] = '{4'b1100, 4'b0100, 2'd2, 1'b1};
        vecs[12] = '{4'b1000, 4'b0000, 2'd2, 1'b1};
        vecs[13] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[14] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[15] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        vecs[16] = '{4'b0000, 4'b0000, 2'd3, 1'b1};
        vecs[17] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
        vecs[18] = '{4'b1001, 4'b0001, 2'd0, 1'b1};
        vecs[19] = '{4'b1000, 4'b0000, 2'd0, 1'b1};
        vecs[20] = '{4'b1001, 4'b1000, 2'd3, 1'b1};
        vecs[21] = '{4'b0000, 4'b0000, 2'd3, 1'b1};
        vecs[22] = '{4'b0000, 4'b0000, 2'd3, 1'b0};

        reset_n = 1'b0;
        req     = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        check_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req);
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, 1'b0);
        end

        // Contended hold: owner 0 keeps requesting while requester 2 waits.
        for (int c = 1; c <= 10; c++) begin
            logic [3:0] eg;
            logic [1:0] ei;
            step((c == 1) ? 4'b0001 : 4'b0101);
            eg = (!HoldEn || c <= 8) ? 4'b0001 : ((c == 9) ? 4'b0000 : 4'b0100);
            ei = (HoldEn && c == 10) ? 2'd2 : 2'd0;
            check_out($sformatf("hold_c%0d", c), eg, ei, 1'b1, HoldEn && (c == 9));
        end
        step(4'b0000);
        check_out("hold_gap", 4'b0000, HoldEn ? 2'd2 : 2'd0, 1'b1, 1'b0);
        step(4'b0000);
        check_out("hold_idle", 4'b0000, HoldEn ? 2'd2 : 2'd0, 1'b0, 1'b0);

        // Lone requester is never forced off.
        for (int c = 1; c <= 20; c++) begin
            step(4'b0010);
            check_out($sformatf("lone_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
        end

        // Owner 1 hands over to 2, then reset lands mid-grant.
        step(4'b0100);
        check_out("pre_rst_gap", 4'b0000, 2'd1, 1'b1, 1'b0);
        step(4'b0100);
        check_out("pre_rst_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
        step(4'b0100);
        check_out("pre_rst_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        req     = 4'b1010;
        #1;
        check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check_out("in_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        step(4'b1010);
        check_out("post_rst", 4'b0010, 2'd1, 1'b1, 1'b0);
        step(4'b1010);
        check_out("post_rst_hold", 4'b0010, 2'd1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
